// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA line buffer
package vga_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH_DEFAULT = 1024;
  typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
endpackage

// File: rtl/vga_lb_ram.sv
// vga_lb_ram: simple dual-port RAM, one write port, one synchronous read port
module vga_lb_ram #(
  parameter int DEPTH = 1024,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: frame-aligned pixel FIFO between a pixel source and VGA display timing
module vga_line_buffer import vga_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DATA_W = vga_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_sof,
  input  logic                   frame_start,
  input  logic                   pix_req,
  output logic [DATA_W-1:0]      rgb,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  state_t state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic full, empty, wr, pop, pop_q;
  always_comb begin
    full = level == LW'(DEPTH);
    empty = level == '0;
    s_ready = !reset && !frame_start && (state == WAIT_SOF || !full);
    wr = s_valid && s_ready && (state == RUN || s_sof);
    pop = pix_req && !empty && !frame_start;
  end
  // RAM output is only exposed in the cycle after a pop; otherwise rgb is black
  assign rgb = pop_q ? rd_data : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_SOF;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      pop_q <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_q <= pop;
      underflow <= underflow || (pix_req && empty);
      if (frame_start) begin
        state <= WAIT_SOF;
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        if (wr) begin
          wr_ptr <= wr_ptr + AW'(1);
          state <= RUN;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(wr) - LW'(pop);
      end
    end
  end
  vga_lb_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .we(wr),
    .waddr(wr_ptr),
    .wdata(s_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
endmodule
